// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: state encoding and counter sizing shared by the multiplier sequencer.
package mult_seq_pkg;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_SHP  = 3'd4;
    localparam logic [2:0] S_SHB  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        CLR  = S_CLR,
        LOAD = S_LOAD,
        ADD  = S_ADD,
        SHP  = S_SHP,
        SHB  = S_SHB,
        DONE = S_DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/mult_seq_cnt.sv
// mult_seq_cnt: iteration counter for the multiplier sequencer.
import mult_seq_pkg::*;

module mult_seq_cnt #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          inc,
    output logic [cnt_width(WIDTH)-1:0]   count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add multiplier control FSM.
// Define MULT_SEQ_SKIP_ZERO_EN to suppress the product load on zero multiplier bits.
import mult_seq_pkg::*;

module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mbit,
    output logic clr,
    output logic ld,
    output logic ldp,
    output logic shp,
    output logic shb,
    output logic busy,
    output logic done
);
    localparam int CW = cnt_width(WIDTH);

    state_t          state, nxt;
    logic [CW-1:0]   count;
    logic            last;

    assign last = (count == CW'(WIDTH - 1));

    mult_seq_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .inc   (state == SHB),
        .count (count)
    );

`ifdef MULT_SEQ_SKIP_ZERO_EN
    logic add_en;
    assign add_en = mbit;
`else
    logic add_en;
    logic unused_mbit;
    assign add_en      = 1'b1;
    assign unused_mbit = mbit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Illegal encodings fall to the default arm: outputs stay 0, return to IDLE.
    always_comb begin
        nxt  = IDLE;
        clr  = 1'b0;
        ld   = 1'b0;
        ldp  = 1'b0;
        shp  = 1'b0;
        shb  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: nxt = start ? CLR : IDLE;
            CLR: begin
                clr  = 1'b1;
                busy = 1'b1;
                nxt  = LOAD;
            end
            LOAD: begin
                ld   = 1'b1;
                busy = 1'b1;
                nxt  = ADD;
            end
            ADD: begin
                ldp  = add_en;
                busy = 1'b1;
                nxt  = last ? DONE : SHP;
            end
            SHP: begin
                shp  = 1'b1;
                busy = 1'b1;
                nxt  = SHB;
            end
            SHB: begin
                shb  = 1'b1;
                busy = 1'b1;
                nxt  = ADD;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule
